// File: rtl/uart_scope_pkg.sv
// uart_scope_pkg: shared FSM states and frame constants for the uart_scope datapath.
// UART_TX_FRAME_CHKSUM_EN lengthens the frame by one checksum byte.
package uart_scope_pkg;
  typedef enum logic [1:0] {IDLE, SEND, WAIT} tx_state_e;
  localparam logic [7:0] UART_FRAME_HEADER = 8'hA5;
`ifdef UART_TX_FRAME_CHKSUM_EN
  localparam int FRAME_LEN = 4;
`else
  localparam int FRAME_LEN = 3;
`endif
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO; read data shows the head word, so a pop takes it on the same edge.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  input  logic                     rd_en_i,
  output logic [WIDTH-1:0]         rd_data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0] count_q, count_d;
  logic push, pop;
  // DEPTH is a power of two, so the count MSB alone marks full
  assign full_o = count_q[AW];
  assign empty_o = count_q == '0;
  assign push = wr_en_i & ~full_o;
  assign pop = rd_en_i & ~empty_o;
  assign count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
  assign rd_data_o = mem_q[rd_ptr_q];
  assign count_o = count_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_q + AW'(push);
      rd_ptr_q <= rd_ptr_q + AW'(pop);
      count_q <= count_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data_i;
  end
endmodule

// File: rtl/uart_tx_frame.sv
// uart_tx_frame: buffers 16-bit samples and sends each as HEADER, high byte, low byte to uart_byte_tx.
// Define UART_TX_FRAME_CHKSUM_EN to append a fourth byte, high ^ low.
module uart_tx_frame
  import uart_scope_pkg::*;
#(
  parameter int         FIFO_DEPTH = 16,
  parameter logic [7:0] HEADER     = UART_FRAME_HEADER
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [15:0]                    s_data,
  input  logic                           s_valid,
  output logic                           s_ready,
  output logic                           byte_en,
  output logic [7:0]                     data_byte,
  input  logic                           tx_done,
  output logic                           busy,
  output logic [$clog2(FIFO_DEPTH):0]    fifo_count
);
  localparam logic [1:0] LAST_IDX = 2'(FRAME_LEN - 1);
  tx_state_e state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [15:0] word_q, word_d, fifo_data;
  logic byte_en_q, byte_en_d;
  logic [7:0] data_byte_q, data_byte_d, frame_byte;
  logic fifo_full, fifo_empty, pop;
  sync_fifo #(.WIDTH(16), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (s_valid),
    .wr_data_i (s_data),
    .rd_en_i   (pop),
    .rd_data_o (fifo_data),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .count_o   (fifo_count)
  );
  assign s_ready = ~fifo_full;
  assign busy = state_q != IDLE;
  assign pop = state_q == IDLE && !fifo_empty;
  assign byte_en = byte_en_q;
  assign data_byte = data_byte_q;
`ifdef UART_TX_FRAME_CHKSUM_EN
  assign frame_byte = idx_q == 2'd3 ? word_q[15:8] ^ word_q[7:0] :
                      idx_q == 2'd2 ? word_q[7:0] :
                      idx_q == 2'd1 ? word_q[15:8] : HEADER;
`else
  assign frame_byte = idx_q == 2'd2 ? word_q[7:0] :
                      idx_q == 2'd1 ? word_q[15:8] : HEADER;
`endif
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    word_d = word_q;
    byte_en_d = 1'b0;
    data_byte_d = data_byte_q;
    case (state_q)
      IDLE: if (!fifo_empty) begin
        word_d = fifo_data;
        idx_d = '0;
        state_d = SEND;
      end
      SEND: begin
        byte_en_d = 1'b1;
        data_byte_d = frame_byte;
        state_d = WAIT;
      end
      WAIT: if (tx_done) begin
        idx_d = idx_q + 2'd1;
        state_d = idx_q == LAST_IDX ? IDLE : SEND;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q <= '0;
      word_q <= '0;
      byte_en_q <= 1'b0;
      data_byte_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      word_q <= word_d;
      byte_en_q <= byte_en_d;
      data_byte_q <= data_byte_d;
    end
  end
endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame: directed checks of framing, latency, FIFO fill, spurious tx_done and reset.
module tb_uart_tx_frame;
  import uart_scope_pkg::*;
  logic clk = 1'b0, rst = 1'b1, s_valid = 1'b0, tx_done_m = 1'b0, tx_done_a = 1'b0, auto_done = 1'b0;
  logic [15:0] s_data = '0;
  logic tx_done, s_ready, byte_en, busy, prev_be = 1'b0;
  logic [7:0] data_byte;
  logic [4:0] fifo_count;
  logic [7:0] got_q[$], exp_q[$];
  int errs = 0, checks = 0, dbl_cnt = 0;

  assign tx_done = tx_done_m | tx_done_a;
  always #10 clk = ~clk;

  uart_tx_frame dut (
    .clk        (clk),
    .rst        (rst),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .byte_en    (byte_en),
    .data_byte  (data_byte),
    .tx_done    (tx_done),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  always @(negedge clk) begin
    if (byte_en) begin
      got_q.push_back(data_byte);
      if (prev_be) dbl_cnt <= dbl_cnt + 1;
    end
    prev_be <= byte_en;
  end

  initial forever begin
    @(negedge clk);
    if (auto_done && byte_en) begin
      repeat (50) @(negedge clk);
      tx_done_a = 1'b1;
      @(negedge clk);
      tx_done_a = 1'b0;
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation still running after 5 ms");
    $fatal(1);
  end

  function automatic logic [7:0] fb(input logic [15:0] w, input int k);
    return k == 0 ? 8'hA5 : k == 1 ? w[15:8] : k == 2 ? w[7:0] : w[15:8] ^ w[7:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic add_exp(input logic [15:0] w, input int n);
    for (int k = 0; k < n; k++) exp_q.push_back(fb(w, k));
  endtask

  task automatic pulse_done();
    tx_done_m = 1'b1;
    @(negedge clk);
    tx_done_m = 1'b0;
  endtask

  task automatic next_byte(input logic [15:0] w, input int k, input int gap);
    repeat (gap) @(negedge clk);
    check("hold_byte", data_byte, fb(w, k - 1));
    pulse_done();
    check("be_gap", byte_en, 1'b0);
    @(negedge clk);
    check("be_next", byte_en, 1'b1);
    check("byte_next", data_byte, fb(w, k));
  endtask

  task automatic rest_of_frame(input logic [15:0] w, input int gap);
    for (int k = 1; k < FRAME_LEN; k++) next_byte(w, k, gap);
    repeat (gap) @(negedge clk);
    pulse_done();
  endtask

  initial begin
    int n, base;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_be", byte_en, 1'b0);
    check("rst_byte", data_byte, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_cnt", fifo_count, 5'd0);
    check("rst_rdy", s_ready, 1'b1);

    // single sample with latency checks
    s_data = 16'h1234; s_valid = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
    check("lat_e0_cnt", fifo_count, 5'd1);
    check("lat_e0_be", byte_en, 1'b0);
    @(negedge clk);
    check("lat_e1_busy", busy, 1'b1);
    check("lat_e1_be", byte_en, 1'b0);
    @(negedge clk);
    check("lat_e2_be", byte_en, 1'b1);
    check("hdr", data_byte, 8'hA5);
    add_exp(16'h1234, FRAME_LEN);
    rest_of_frame(16'h1234, 50);
    check("busy_end", busy, 1'b0);

    // spurious tx_done in IDLE and in SEND
    base = got_q.size();
    pulse_done();
    repeat (5) @(negedge clk);
    check("idle_done_nobyte", got_q.size(), base);
    check("idle_done_busy", busy, 1'b0);
    s_data = 16'hBEEF; s_valid = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
    @(negedge clk);
    tx_done_m = 1'b1;
    @(negedge clk);
    tx_done_m = 1'b0;
    check("send_done_be", byte_en, 1'b1);
    check("send_done_hdr", data_byte, 8'hA5);
    @(negedge clk);
    check("send_done_be0", byte_en, 1'b0);
    check("send_done_busy", busy, 1'b1);
    add_exp(16'hBEEF, FRAME_LEN);
    rest_of_frame(16'hBEEF, 5);

    // simultaneous push and pop
    s_data = 16'hA1B2; s_valid = 1'b1;
    @(negedge clk);
    s_data = 16'hC3D4;
    @(negedge clk);
    s_valid = 1'b0;
    check("pp_cnt_a", fifo_count, 5'd1);
    @(negedge clk);
    check("pp_hdr_a", data_byte, 8'hA5);
    add_exp(16'hA1B2, FRAME_LEN);
    rest_of_frame(16'hA1B2, 5);
    s_data = 16'h0F0F; s_valid = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
    check("pp_cnt_b", fifo_count, 5'd1);
    check("pp_busy_b", busy, 1'b1);
    @(negedge clk);
    check("pp_be_b", byte_en, 1'b1);
    check("pp_hdr_b", data_byte, 8'hA5);
    add_exp(16'hC3D4, FRAME_LEN);
    rest_of_frame(16'hC3D4, 5);
    @(negedge clk);
    @(negedge clk);
    check("pp_be_c", byte_en, 1'b1);
    add_exp(16'h0F0F, FRAME_LEN);
    rest_of_frame(16'h0F0F, 5);
    repeat (3) @(negedge clk);
    check("pp_end_busy", busy, 1'b0);
    check("pp_end_cnt", fifo_count, 5'd0);

    // fill: 16 buffered plus one in flight, then one extra push must stall
    base = got_q.size();
    for (int i = 0; i < 17; i++) begin
      s_data = 16'(i); s_valid = 1'b1;
      check("fill_rdy", s_ready, 1'b1);
      @(negedge clk);
      add_exp(16'(i), FRAME_LEN);
    end
    check("fill_cnt", fifo_count, 5'd16);
    check("fill_full", s_ready, 1'b0);
    s_data = 16'h0011;
    repeat (20) @(negedge clk);
    check("fill_stall", s_ready, 1'b0);
    check("fill_hdr_only", got_q.size(), base + 1);
    auto_done = 1'b1;
    pulse_done();
    n = 0;
    while (!s_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("fill_ready", s_ready, 1'b1);
    check("fill_frame0_done", got_q.size(), base + FRAME_LEN);
    @(negedge clk);
    s_valid = 1'b0;
    add_exp(16'h0011, FRAME_LEN);
    n = 0;
    while ((got_q.size() < base + 18 * FRAME_LEN || busy) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check("fill_all_sent", got_q.size(), base + 18 * FRAME_LEN);
    check("fill_idle", busy, 1'b0);
    auto_done = 1'b0;

    // reset during WAIT of byte 1 with three words queued
    s_data = 16'h1111; s_valid = 1'b1;
    @(negedge clk);
    s_data = 16'h2222;
    @(negedge clk);
    s_data = 16'h3333;
    @(negedge clk);
    s_data = 16'h4444;
    @(negedge clk);
    s_valid = 1'b0;
    add_exp(16'h1111, 2);
    next_byte(16'h1111, 1, 5);
    repeat (3) @(negedge clk);
    check("mid_cnt", fifo_count, 5'd3);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_be", byte_en, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_cnt", fifo_count, 5'd0);
    check("mid_rst_byte", data_byte, 8'h00);
    rst = 1'b0;
    @(negedge clk);
    check("mid_rdy", s_ready, 1'b1);
    s_data = 16'h5678; s_valid = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("mid_be", byte_en, 1'b1);
    check("mid_hdr", data_byte, 8'hA5);
    add_exp(16'h5678, FRAME_LEN);
    rest_of_frame(16'h5678, 5);
    repeat (10) @(negedge clk);
    check("mid_flushed_busy", busy, 1'b0);
    check("mid_flushed_cnt", fifo_count, 5'd0);

    check("be_single_cycle", dbl_cnt, 0);
    check("stream_len", got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) check("stream", got_q[i], exp_q[i]);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
